// File: rtl/regex_cpu_memory_arbiter_pkg.sv
// Shared constants for the multi-core regex instruction-memory path.
package regex_cpu_memory_arbiter_pkg;

  // Id/pointer width that stays at least one bit wide for tiny core counts.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regex_cpu_memory_arbiter_rr_arbiter.sv
// N-way round-robin priority select with its own pointer register.
// The pointer moves to the slot just past the winner whenever a grant is issued.
module rr_arbiter
  import regex_cpu_memory_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid
);

  logic [ID_W-1:0] ptr;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      automatic int idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

  // Explicit wrap so non-power-of-two core counts never point past the last core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/regex_cpu_memory_arbiter.sv
// Shares one single-port instruction BRAM between N_CPU cores: one read per cycle,
// round-robin granted, each word returned to its requester after MEM_LATENCY cycles.
module regex_cpu_memory_arbiter
  import regex_cpu_memory_arbiter_pkg::*;
#(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CPU-1:0]                     cpu_memory_valid,
  input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_memory_addr,
  output logic [N_CPU-1:0]                     cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]              cpu_memory_data,
  output logic                                 bram_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]         bram_addr,
  input  logic [MEMORY_WIDTH-1:0]              bram_data,
  output logic                                 busy
);

  localparam int ID_W = id_width(N_CPU);

  logic [N_CPU-1:0]       pending;
  logic [N_CPU-1:0]       eligible;
  logic [N_CPU-1:0]       grant;
  logic [N_CPU-1:0]       resp_mask;
  logic [ID_W-1:0]        grant_id;
  logic                   grant_valid;
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [ID_W-1:0]        pipe_id [MEM_LATENCY];

  // A core with a read outstanding is masked, so it never holds two reads.
  assign eligible = cpu_memory_valid & ~pending;

  rr_arbiter #(
    .N    (N_CPU),
    .ID_W (ID_W)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (eligible),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign bram_en   = grant_valid & rst;
  assign bram_addr = cpu_memory_addr[grant_id*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

  always_comb begin
    resp_mask = '0;
    if (pipe_valid[MEM_LATENCY-1]) resp_mask[pipe_id[MEM_LATENCY-1]] = 1'b1;
  end

  assign cpu_memory_ready = resp_mask;
  assign cpu_memory_data  = bram_data;
  assign busy             = rst & ((|pending) | (|cpu_memory_valid));

  // The in-flight shift register mirrors the BRAM latency and carries the requester id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      pipe_valid <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pending       <= (pending | grant) & ~resp_mask;
      pipe_valid[0] <= grant_valid;
      pipe_id[0]    <= grant_id;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_regex_cpu_memory_arbiter.sv
// Bench for the instruction-memory arbiter: a latency-1 and a latency-3 build share
// the same core stimulus and are each checked every cycle against a timestamp model.
module tb_regex_cpu_memory_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  valid = '0;
  logic [AW-1:0] addr [N];
  logic [N*AW-1:0] addr_bus;

  logic [N-1:0]  ready [2];
  logic [W-1:0]  data  [2];
  logic          en    [2];
  logic [AW-1:0] baddr [2];
  logic [W-1:0]  bdata [2];
  logic          busy  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat [2] = '{1, 3};
  int ptr [2];
  int resp_at [2][N];
  logic [AW-1:0] gaddr [2][N];

  always #5 clk = ~clk;

  assign addr_bus = {addr[3], addr[2], addr[1], addr[0]};

  regex_cpu_memory_arbiter #(.N_CPU(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .cpu_memory_valid(valid), .cpu_memory_addr(addr_bus),
    .cpu_memory_ready(ready[0]), .cpu_memory_data(data[0]), .bram_en(en[0]),
    .bram_addr(baddr[0]), .bram_data(bdata[0]), .busy(busy[0]));

  regex_cpu_memory_arbiter #(.N_CPU(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .cpu_memory_valid(valid), .cpu_memory_addr(addr_bus),
    .cpu_memory_ready(ready[1]), .cpu_memory_data(data[1]), .bram_en(en[1]),
    .bram_addr(baddr[1]), .bram_data(bdata[1]), .busy(busy[1]));

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    return {5'b0, a} ^ 16'hA5A5;
  endfunction

  // BRAM models: data appears lat cycles after the enable edge, garbage otherwise.
  logic [AW-1:0] bp0_addr;
  logic          bp0_en = 1'b0;
  logic [AW-1:0] bp1_addr [3];
  logic          bp1_en   [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    bp0_addr    <= baddr[0];
    bp0_en      <= en[0];
    bp1_addr[0] <= baddr[1];
    bp1_en[0]   <= en[1];
    for (int i = 1; i < 3; i++) begin
      bp1_addr[i] <= bp1_addr[i-1];
      bp1_en[i]   <= bp1_en[i-1];
    end
  end

  assign bdata[0] = bp0_en    ? mem_word(bp0_addr)    : 16'hDEAD;
  assign bdata[1] = bp1_en[2] ? mem_word(bp1_addr[2]) : 16'hDEAD;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    ptr[d] = 0;
    for (int i = 0; i < N; i++) resp_at[d][i] = -1;
  endtask

  // Model: a core is pending from grant until its due cycle; search starts at ptr.
  task automatic model_step(input int d);
    int w;
    logic [N-1:0] exp_ready;
    logic [W-1:0] exp_data;
    logic         pend_any;
    w = -1;
    exp_ready = '0;
    exp_data = '0;
    pend_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      automatic int i = (ptr[d] + k) % N;
      if (w < 0 && valid[i] && resp_at[d][i] < 0) w = i;
    end
    for (int i = 0; i < N; i++) begin
      if (resp_at[d][i] >= 0) pend_any = 1'b1;
      if (resp_at[d][i] == cyc) begin
        exp_ready[i] = 1'b1;
        exp_data = mem_word(gaddr[d][i]);
      end
    end
    check_output($sformatf("dut%0d_bram_en", d), 32'(en[d]), 32'(w >= 0));
    if (w >= 0) check_output($sformatf("dut%0d_bram_addr", d), 32'(baddr[d]), 32'(addr[w]));
    check_output($sformatf("dut%0d_ready", d), 32'(ready[d]), 32'(exp_ready));
    if (exp_ready != 0) check_output($sformatf("dut%0d_data", d), 32'(data[d]), 32'(exp_data));
    check_output($sformatf("dut%0d_busy", d), 32'(busy[d]), 32'(pend_any | (|valid)));
    for (int i = 0; i < N; i++) if (resp_at[d][i] == cyc) resp_at[d][i] = -1;
    if (w >= 0) begin
      resp_at[d][w] = cyc + lat[d];
      gaddr[d][w]   = addr[w];
      ptr[d]        = (w + 1) % N;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) model_reset(d);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          model_reset(d);
          check_output($sformatf("dut%0d_rst_ready", d), 32'(ready[d]), 32'd0);
          check_output($sformatf("dut%0d_rst_en", d), 32'(en[d]), 32'd0);
          check_output($sformatf("dut%0d_rst_busy", d), 32'(busy[d]), 32'd0);
        end else begin
          model_step(d);
        end
      end
      cyc++;
    end
  end

  task automatic step(input logic [N-1:0] v);
    @(posedge clk);
    #1;
    valid = v;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) addr[i] = '0;
    valid = 4'b1111;
    apply_stimulus(4'b1111, 2);
    do_reset();

    // Single request from core 2.
    addr[2] = 11'h010;
    step(4'b0100);
    #2;
    check_output("s1_en", 32'(en[0]), 32'd1);
    check_output("s1_addr", 32'(baddr[0]), 32'h010);
    step(4'b0000);
    #2;
    check_output("s1_ready", 32'(ready[0]), 32'b0100);
    check_output("s1_data", 32'(data[0]), 32'hA5B5);
    check_output("s1_busy_hi", 32'(busy[0]), 32'd1);
    step(4'b0000);
    #2;
    check_output("s1_busy_lo", 32'(busy[0]), 32'd0);
    apply_stimulus(4'b0000, 4);

    // All cores requesting continuously: grant order 0,1,2,3 repeating.
    do_reset();
    for (int i = 0; i < N; i++) addr[i] = AW'(i + 1);
    for (int k = 0; k < 12; k++) begin
      step(4'b1111);
      #2;
      check_output($sformatf("s2_rr_en_%0d", k), 32'(en[0]), 32'd1);
      check_output($sformatf("s2_rr_addr_%0d", k), 32'(baddr[0]), 32'((k % 4) + 1));
    end
    apply_stimulus(4'b0000, 5);

    // Cores 1 and 3 both holding valid: core 3 slots in while core 1 is pending.
    do_reset();
    addr[1] = 11'h100;
    addr[3] = 11'h300;
    for (int k = 0; k < 6; k++) begin
      step(4'b1010);
      #2;
      check_output($sformatf("s3_addr_%0d", k), 32'(baddr[0]), (k % 2 == 0) ? 32'h100 : 32'h300);
    end
    apply_stimulus(4'b0000, 4);

    // Core 0 drops valid and changes address right after its grant.
    do_reset();
    addr[0] = 11'h055;
    step(4'b0001);
    #2;
    check_output("s4_addr", 32'(baddr[0]), 32'h055);
    step(4'b0000);
    addr[0] = 11'h7FF;
    #2;
    check_output("s4_ready", 32'(ready[0]), 32'b0001);
    check_output("s4_data", 32'(data[0]), 32'hA5F0);
    check_output("s4_no_regrant", 32'(en[0]), 32'd0);
    apply_stimulus(4'b0000, 4);

    // Asynchronous reset while reads are in flight.
    do_reset();
    addr[1] = 11'h020;
    addr[2] = 11'h040;
    apply_stimulus(4'b0110, 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("s5_async_ready%0d", d), 32'(ready[d]), 32'd0);
      check_output($sformatf("s5_async_busy%0d", d), 32'(busy[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply_stimulus(4'b0000, 5);

    // Latency-3 build: four back-to-back grants, responses three cycles later in order.
    do_reset();
    for (int i = 0; i < N; i++) addr[i] = AW'(i + 1);
    for (int k = 0; k < 8; k++) begin
      step((k < 4) ? 4'b1111 : 4'b0000);
      #2;
      if (k < 4) check_output($sformatf("s6_en_%0d", k), 32'(en[1]), 32'd1);
      if (k >= 3 && k <= 6) begin
        check_output($sformatf("s6_ready_%0d", k), 32'(ready[1]), 32'(1 << (k - 3)));
        check_output($sformatf("s6_data_%0d", k), 32'(data[1]), 32'(mem_word(AW'(k - 2))));
      end
    end
    apply_stimulus(4'b0000, 3);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
